// File: rtl/axis_frame_source.sv
// AXI-Stream frame source: buffers one frame written through a simple port, then streams it
// out with tvalid/tready handshaking and an optional idle gap before the next load.
`timescale 1ns/1ps

module axis_frame_source #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned GAP        = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_last,
  output logic                    wr_ready,
  output logic [$clog2(DEPTH):0]  frame_len,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {StLoad, StSend, StGap} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]             frame_len_q, frame_len_d;
  logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic          wr_accept;
  logic          commit;
  logic          beat_done;
  logic [AW-1:0] rd_next;

  assign wr_accept = wr_en && (state_q == StLoad);
  assign commit    = wr_accept && (wr_last || (wr_ptr_q == AW'(DEPTH - 1)));
  assign beat_done = tvalid_q && m_axis_tready;
  assign rd_next   = rd_ptr_q + AW'(1);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_len_d = frame_len_q;
    gap_cnt_d   = gap_cnt_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;

    unique case (state_q)
      StLoad: begin
        if (wr_accept) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (commit) begin
            frame_len_d = {1'b0, wr_ptr_q} + (AW+1)'(1);
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            state_d     = StSend;
            tvalid_d    = 1'b1;
            tlast_d     = (wr_ptr_q == '0);
            // mem[0] is only written on this same edge for a 1-sample frame
            tdata_d     = (wr_ptr_q == '0) ? wr_data : mem_q[0];
          end
        end
      end
      StSend: begin
        if (beat_done) begin
          if (tlast_q) begin
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            rd_ptr_d  = '0;
            gap_cnt_d = '0;
            state_d   = (GAP > 0) ? StGap : StLoad;
          end else begin
            rd_ptr_d = rd_next;
            tdata_d  = mem_q[rd_next];
            tlast_d  = ({1'b0, rd_next} == (frame_len_q - (AW+1)'(1)));
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GW'(GAP - 1)) begin
          gap_cnt_d = '0;
          state_d   = StLoad;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StLoad;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_len_q <= '0;
      gap_cnt_q   <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_len_q <= frame_len_d;
      gap_cnt_q   <= gap_cnt_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  // Sample storage needs no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign wr_ready      = (state_q == StLoad);
  assign busy          = (state_q != StLoad);
  assign frame_len     = frame_len_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_frame_source.sv
// Scoreboard bench for axis_frame_source: one instance with GAP=0, one with GAP=7.
`timescale 1ns/1ps

module tb_axis_frame_source;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        wr_en = 1'b0, wr_last = 1'b0, wr_ready, busy;
  logic [15:0] wr_data = '0;
  logic [4:0]  frame_len;
  logic [15:0] tdata;
  logic        tvalid, tlast;
  logic        tready = 1'b0;

  logic        g_wr_en = 1'b0, g_wr_last = 1'b0, g_wr_ready, g_busy;
  logic [15:0] g_wr_data = '0;
  logic [4:0]  g_frame_len;
  logic [15:0] g_tdata;
  logic        g_tvalid, g_tlast;
  logic        g_tready = 1'b0;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          zeros;
  logic [16:0] exp_q[$];
  logic [16:0] gexp_q[$];
  logic        stall_prev = 1'b0;
  logic [16:0] held;
  logic [5:0]  pat;

  always #5 clk = ~clk;

  axis_frame_source #(.DATA_WIDTH(16), .DEPTH(16), .GAP(0)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready), .frame_len(frame_len), .busy(busy), .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast)
  );

  axis_frame_source #(.DATA_WIDTH(16), .DEPTH(16), .GAP(7)) u_gap (
    .clk(clk), .rst(rst), .wr_en(g_wr_en), .wr_data(g_wr_data), .wr_last(g_wr_last),
    .wr_ready(g_wr_ready), .frame_len(g_frame_len), .busy(g_busy), .m_axis_tdata(g_tdata),
    .m_axis_tvalid(g_tvalid), .m_axis_tready(g_tready), .m_axis_tlast(g_tlast)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] d, input logic l);
    wr_en = 1'b1; wr_data = d; wr_last = l;
    cycles(1);
    wr_en = 1'b0; wr_last = 1'b0;
  endtask

  task automatic gwr(input logic [15:0] d, input logic l);
    g_wr_en = 1'b1; g_wr_data = d; g_wr_last = l;
    cycles(1);
    g_wr_en = 1'b0; g_wr_last = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_tvalid_held", tvalid, 1);
        check("stall_beat_held", {tlast, tdata}, held);
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL beat_unexpected: got %0h, expected no beat", {tlast, tdata});
        end else begin
          check("beat", {tlast, tdata}, exp_q.pop_front());
        end
      end
      stall_prev = tvalid && !tready;
      held       = {tlast, tdata};
      if (g_tvalid && g_tready) begin
        if (gexp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL gap_beat_unexpected: got %0h, expected no beat", {g_tlast, g_tdata});
        end else begin
          check("gap_beat", {g_tlast, g_tdata}, gexp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cycles(1);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_len", frame_len, 0);

    // Basic 4-sample frame, tready high
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({(i == 3), 16'(i + 1)});
      wr(16'(i + 1), (i == 3));
    end
    check("basic_valid_after_commit", tvalid, 1);
    check("basic_frame_len", frame_len, 4);
    check("basic_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      check("basic_valid_run", tvalid, 1);
      check("basic_tlast", tlast, (i == 3));
      cycles(1);
    end
    check("basic_valid_drop", tvalid, 0);
    check("basic_wr_ready_back", wr_ready, 1);

    // Backpressure: tready 0,0,1,0,1,1
    tready = 1'b0;
    exp_q.push_back({1'b0, 16'd10}); wr(16'd10, 1'b0);
    exp_q.push_back({1'b0, 16'd20}); wr(16'd20, 1'b0);
    exp_q.push_back({1'b1, 16'd30}); wr(16'd30, 1'b1);
    check("bp_first_tdata", tdata, 10);
    pat = 6'b110100;
    for (int i = 0; i < 6; i++) begin
      tready = pat[i];
      cycles(1);
    end
    check("bp_done_tvalid", tvalid, 0);
    tready = 1'b1;

    // Auto-commit at DEPTH, then a 1-sample frame
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({(i == 15), 16'h0100 + 16'(i)});
      wr(16'h0100 + 16'(i), 1'b0);
    end
    check("auto_frame_len", frame_len, 16);
    check("auto_valid", tvalid, 1);
    cycles(15);
    check("auto_last_tlast", tlast, 1);
    check("auto_last_tdata", tdata, 16'h010F);
    cycles(1);
    check("auto_done_tvalid", tvalid, 0);
    exp_q.push_back({1'b1, 16'h7FFF});
    wr(16'h7FFF, 1'b1);
    check("one_frame_len", frame_len, 1);
    check("one_tlast", tlast, 1);
    check("one_tdata", tdata, 16'h7FFF);
    cycles(1);
    check("one_done_tvalid", tvalid, 0);
    check("one_wr_ready", wr_ready, 1);

    // GAP=7 instance: 2-sample frame with writes pulsed during SEND/GAP
    g_tready = 1'b1;
    gexp_q.push_back({1'b0, 16'h00A1}); gwr(16'h00A1, 1'b0);
    gexp_q.push_back({1'b1, 16'h00A2}); gwr(16'h00A2, 1'b1);
    zeros = 0;
    for (int k = 0; k < 9; k++) begin
      g_wr_en = 1'b1;
      g_wr_data = 16'hDE00 + 16'(k);
      if (k >= 2 && !g_wr_ready) zeros++;
      if (k == 4) begin
        check("gap_busy", g_busy, 1);
        check("gap_tvalid", g_tvalid, 0);
      end
      cycles(1);
    end
    g_wr_en = 1'b0;
    check("gap_low_cycles", zeros, 7);
    check("gap_wr_ready_back", g_wr_ready, 1);
    check("gap_busy_clear", g_busy, 0);
    gexp_q.push_back({1'b1, 16'h00B1});
    gwr(16'h00B1, 1'b1);
    check("gap_next_frame_len", g_frame_len, 1);
    cycles(2);

    // Asynchronous reset during beat 2 of 5
    tready = 1'b1;
    exp_q.push_back({1'b0, 16'h0051});
    for (int i = 0; i < 5; i++) wr(16'h0051 + 16'(i), (i == 4));
    cycles(1);
    check("ar_beat2_tdata", tdata, 16'h0052);
    #1 rst = 1'b0;
    #1;
    check("ar_tvalid_async", tvalid, 0);
    check("ar_tlast_async", tlast, 0);
    check("ar_tdata_async", tdata, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    cycles(1);
    check("ar_frame_len", frame_len, 0);
    check("ar_wr_ready", wr_ready, 1);
    check("ar_busy", busy, 0);
    zeros = 0;
    for (int i = 0; i < 5; i++) begin
      if (tvalid) zeros++;
      cycles(1);
    end
    check("ar_no_residual", zeros, 0);
    exp_q.push_back({1'b1, 16'h0099});
    wr(16'h0099, 1'b1);
    check("ar_new_frame_len", frame_len, 1);
    cycles(3);

    check("scoreboard_drained", exp_q.size(), 0);
    check("gap_scoreboard_drained", gexp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_frame_source.md
Name: axis_frame_source

Overview:
- AXI-Stream master that transmits tlast-terminated sample frames into the FIR filter's slave port.
- A local controller loads a frame through a simple write port into an internal buffer; the block then streams the frame out with full tvalid/tready handshaking.
- It adds a programmable idle gap between frames, so the downstream filter's flush cycles complete before the next frame starts.

Parameters:
- DATA_WIDTH, 16, sample width in bits.
- DEPTH, 16, maximum frame length in samples; must be a power of 2, minimum 2.
- GAP, 0, idle cycles inserted after each frame's last beat before loading reopens.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-low. Asserted low clears all state immediately.
- wr_en  in  1  write strobe for a sample.
- wr_data  in  DATA_WIDTH  sample to store.
- wr_last  in  1  marks the final sample of the frame; qualified by wr_en.
- wr_ready  out  1  write accepted when wr_en && wr_ready.
- frame_len  out  $clog2(DEPTH)+1  length of the committed frame; holds until the next commit.
- busy  out  1  high in SEND or GAP.
- m_axis_tdata  out  DATA_WIDTH  sample data (registered).
- m_axis_tvalid  out  1  beat valid (registered).
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of the frame (registered).

Behaviour:
- Reset values (rst low):
  - State = LOAD; wr_ptr, rd_ptr, gap counter and frame_len = 0.
  - m_axis_tvalid, m_axis_tlast and m_axis_tdata = 0.
  - wr_ready = 1 after release; busy = 0.
  - Buffer contents are don't-care.
- States and transitions:
  - LOAD: wr_ready = 1.
    - An accepted write stores wr_data at mem[wr_ptr] and increments wr_ptr.
    - If wr_last is set, or wr_ptr == DEPTH-1 (buffer full, auto-commit), the write commits the frame:
      - frame_len <= wr_ptr+1, wr_ptr <= 0, state -> SEND.
      - On the same edge the output register loads mem[0], or wr_data directly when the frame length is 1.
    - m_axis_tvalid is high on the cycle after commit. Commit-to-first-valid latency is 1 cycle.
  - SEND: wr_ready = 0; writes are ignored.
    - m_axis_tvalid = 1.
    - m_axis_tlast = 1 exactly when the presented beat index == frame_len-1.
    - Handshake happens on tvalid && tready at a clock edge:
      - Non-last beat: the next sample (rd_ptr+1) loads into the output register on the same edge, so back-to-back beats run with no bubble.
      - Last beat: m_axis_tvalid and m_axis_tlast go to 0 next cycle and rd_ptr resets to 0. State -> GAP if GAP > 0, else LOAD.
    - While tvalid && !tready, tdata and tlast are held stable. tvalid never drops before acceptance.
  - GAP: counts GAP cycles with tvalid = 0 and wr_ready = 0, then -> LOAD.
- Frame rules:
  - The minimum frame is 1 sample. A 1-sample frame has tlast set on its only beat.
  - Empty frames cannot exist.
- Boundaries:
  - wr_en is ignored in SEND and GAP; the write is lost and the writer must watch wr_ready.
  - On the DEPTH-th write without wr_last, the frame auto-commits with frame_len = DEPTH.
  - m_axis_tready may toggle arbitrarily. The frame is still emitted in order, with no duplicated or dropped beats.
  - Reset asserted mid-frame: outputs drop asynchronously and the frame is discarded. After release the block returns to LOAD.
- Ready throughput: with m_axis_tready held high, a frame of N samples occupies exactly N consecutive tvalid cycles.

Test Plan:
- Reset/idle: hold rst low for 3 cycles, then release -> tvalid=0, tlast=0, tdata=0, wr_ready=1, busy=0, frame_len=0.
- Basic frame, GAP=0:
  - Stimulus: write 1,2,3,4 with wr_last on 4, tready held 1.
  - Required: tvalid on the cycle after commit; beats 1,2,3,4 on 4 consecutive cycles; tlast only on 4; frame_len=4; wr_ready high again the cycle after the last beat.
- Backpressure:
  - Stimulus: 3-sample frame 10,20,30; tready pattern 0,0,1,0,1,1.
  - Required: tdata stays 10 during both stalls; exactly 3 beats accepted in order; tlast held with 30 until accepted.
- Auto-commit and length 1:
  - Stimulus: DEPTH=16, write 16 samples with no wr_last.
  - Required: frame_len=16 and tlast on the 16th beat.
  - Then write a single sample 0x7FFF with wr_last -> one beat with tlast=1, frame_len=1.
- Gap and ignored writes:
  - Stimulus: GAP=7, send a 2-sample frame, keep wr_en pulsing during SEND/GAP.
  - Required: exactly 7 cycles with wr_ready=0 after the last beat; no pulsed write appears in the next frame.
- Async reset mid-frame:
  - Stimulus: drive rst low between clock edges during beat 2 of 5.
  - Required: tvalid drops immediately without waiting for a clock edge. After release: LOAD state, frame_len=0, no residual beats.
